// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - 8-digit hex scanner for a common-anode seven-segment bank
// Optional leading-zero blanking: define DISP_LZ_BLANK_EN.
module hex_display_scanner #(
   parameter int REFRESH_DIV = 50000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] value_in,
   input  logic        value_valid,
   output logic        value_ready,
   output logic [6:0]  seg_out,
   output logic [7:0]  digit_out,
   output logic        frame_done
);

   localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(REFRESH_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    idx_q, idx_d;
   logic [31:0]   disp_q, disp_d;
   logic [31:0]   pend_q, pend_d;
   logic          pend_full_q, pend_full_d;
   logic [6:0]    seg_q, seg_d;
   logic [7:0]    digit_q, digit_d;
   logic          frame_done_q, frame_done_d;

   logic          tick;
   logic          boundary;
   logic          accept;
   logic [4:0]    nib_sh;
   logic [3:0]    nibble;
   logic          lz_blank;

   function automatic logic [6:0] decode(input logic [3:0] n);
      case (n)
         4'h0: decode = 7'h40;
         4'h1: decode = 7'h79;
         4'h2: decode = 7'h24;
         4'h3: decode = 7'h30;
         4'h4: decode = 7'h19;
         4'h5: decode = 7'h12;
         4'h6: decode = 7'h02;
         4'h7: decode = 7'h78;
         4'h8: decode = 7'h00;
         4'h9: decode = 7'h10;
         4'hA: decode = 7'h08;
         4'hB: decode = 7'h03;
         4'hC: decode = 7'h46;
         4'hD: decode = 7'h21;
         4'hE: decode = 7'h06;
         default: decode = 7'h0E;
      endcase
   endfunction

   assign value_ready = !pend_full_q;
   assign seg_out     = seg_q;
   assign digit_out   = digit_q;
   assign frame_done  = frame_done_q;

   assign tick     = (cnt_q == CNT_MAX);
   assign boundary = tick && (idx_q == 3'd7);
   assign accept   = value_valid && !pend_full_q;
   assign nib_sh   = {idx_q, 2'b00};
   assign nibble   = disp_q[nib_sh +: 4];

`ifdef DISP_LZ_BLANK_EN
   // Digit k>0 is dark when it and every higher nibble are zero.
   assign lz_blank = (idx_q != 3'd0) && ((disp_q >> nib_sh) == 32'd0);
`else
   assign lz_blank = 1'b0;
`endif

   always_comb begin
      cnt_d        = tick ? '0 : cnt_q + CW'(1);
      idx_d        = tick ? idx_q + 3'd1 : idx_q;
      disp_d       = disp_q;
      pend_d       = pend_q;
      pend_full_d  = pend_full_q;
      frame_done_d = boundary;
      // Accept needs an empty slot and a swap needs a full one, so they never collide.
      if (accept) begin
         pend_d      = value_in;
         pend_full_d = 1'b1;
      end
      if (boundary && pend_full_q) begin
         disp_d      = pend_q;
         pend_full_d = 1'b0;
      end
      if (tick || lz_blank) begin
         seg_d   = 7'h7F;
         digit_d = 8'hFF;
      end else begin
         seg_d   = decode(nibble);
         digit_d = ~(8'd1 << idx_q);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q        <= '0;
         idx_q        <= 3'd0;
         disp_q       <= 32'd0;
         pend_q       <= 32'd0;
         pend_full_q  <= 1'b0;
         seg_q        <= 7'h7F;
         digit_q      <= 8'hFF;
         frame_done_q <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         idx_q        <= idx_d;
         disp_q       <= disp_d;
         pend_q       <= pend_d;
         pend_full_q  <= pend_full_d;
         seg_q        <= seg_d;
         digit_q      <= digit_d;
         frame_done_q <= frame_done_d;
      end
   end

endmodule

// File: tb/tb_hex_display_scanner.sv
// tb/tb_hex_display_scanner.sv - directed bench for hex_display_scanner (REFRESH_DIV=4)
module tb_hex_display_scanner;

   logic        clk;
   logic        rst_n;
   logic [31:0] value_in;
   logic        value_valid;
   logic        value_ready;
   logic [6:0]  seg_out;
   logic [7:0]  digit_out;
   logic        frame_done;

   int tests = 0;
   int fails = 0;

   logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

   hex_display_scanner #(.REFRESH_DIV(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .value_in    (value_in),
      .value_valid (value_valid),
      .value_ready (value_ready),
      .seg_out     (seg_out),
      .digit_out   (digit_out),
      .frame_done  (frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] lit_mask(input logic [31:0] v);
      logic [7:0] m;
`ifdef DISP_LZ_BLANK_EN
      m = 8'h01;
      for (int k = 1; k < 8; k++)
         if ((v >> (4 * k)) != 32'd0) m[k] = 1'b1;
`else
      m = 8'hFF;
`endif
      return m;
   endfunction

   task automatic wait_frame(input string tag);
      int n;
      n = 0;
      do begin
         step();
         n++;
      end while (!frame_done && n < 100);
      chk({tag, " frame_done seen"}, {31'd0, frame_done}, 32'd1);
   endtask

   // Starts on the blank cycle right after a boundary; ends on the next one.
   task automatic check_frame(input string tag, input logic [31:0] v);
      logic [7:0] lit;
      logic [6:0] es;
      logic [7:0] ed;
      lit = lit_mask(v);
      for (int d = 0; d < 8; d++) begin
         es = lit[d] ? seg_tbl[v[4*d +: 4]] : 7'h7F;
         ed = lit[d] ? ~(8'd1 << d) : 8'hFF;
         for (int c = 0; c < 3; c++) begin
            step();
            if (d == 0 && c == 0) value_valid = 1'b0;
            chk($sformatf("%s d%0d c%0d seg", tag, d, c), {25'd0, seg_out}, {25'd0, es});
            chk($sformatf("%s d%0d c%0d digit", tag, d, c), {24'd0, digit_out}, {24'd0, ed});
         end
         step();
         chk($sformatf("%s d%0d blank seg", tag, d), {25'd0, seg_out}, 32'h7F);
         chk($sformatf("%s d%0d blank digit", tag, d), {24'd0, digit_out}, 32'hFF);
         chk($sformatf("%s d%0d frame_done", tag, d), {31'd0, frame_done}, (d == 7) ? 32'd1 : 32'd0);
      end
   endtask

   initial begin
      rst_n       = 1'b0;
      value_valid = 1'b0;
      value_in    = 32'd0;
      repeat (3) step();
      chk("reset seg", {25'd0, seg_out}, 32'h7F);
      chk("reset digit", {24'd0, digit_out}, 32'hFF);
      chk("reset ready", {31'd0, value_ready}, 32'd1);
      chk("reset frame_done", {31'd0, frame_done}, 32'd0);

      rst_n = 1'b1;
      step();
      chk("release seg", {25'd0, seg_out}, 32'h40);
      chk("release digit", {24'd0, digit_out}, 32'hFE);

      value_in    = 32'h89AB_CDEF;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      chk("accept ready low", {31'd0, value_ready}, 32'd0);
      wait_frame("89AB");
      check_frame("89AB", 32'h89AB_CDEF);

      value_in    = 32'h1;
      value_valid = 1'b1;
      step();
      value_in = 32'h2;
      begin
         int n;
         n = 0;
         do begin
            step();
            n++;
            if (!frame_done) chk("bp ready low", {31'd0, value_ready}, 32'd0);
         end while (!frame_done && n < 100);
      end
      chk("bp frame_done", {31'd0, frame_done}, 32'd1);
      chk("bp ready rises", {31'd0, value_ready}, 32'd1);
      check_frame("bp show1", 32'h1);
      check_frame("bp show2", 32'h2);

      repeat (31) step();
      chk("pre-boundary frame_done", {31'd0, frame_done}, 32'd0);
      value_in    = 32'hFFFF_FFFF;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      chk("bnd accept frame_done", {31'd0, frame_done}, 32'd1);
      chk("bnd accept ready low", {31'd0, value_ready}, 32'd0);
      check_frame("bnd keep2", 32'h2);
      check_frame("bnd showF", 32'hFFFF_FFFF);

      value_in    = 32'h1234_5678;
      value_valid = 1'b1;
      step();
      value_valid = 1'b0;
      chk("mid pend ready", {31'd0, value_ready}, 32'd0);
      repeat (20) step();
      chk("mid idx5 digit", {24'd0, digit_out}, 32'hDF);
      chk("mid idx5 seg", {25'd0, seg_out}, 32'h0E);
      #2 rst_n = 1'b0;
      #1;
      chk("async seg", {25'd0, seg_out}, 32'h7F);
      chk("async digit", {24'd0, digit_out}, 32'hFF);
      chk("async ready", {31'd0, value_ready}, 32'd1);
      chk("async frame_done", {31'd0, frame_done}, 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("restart seg", {25'd0, seg_out}, 32'h40);
      chk("restart digit", {24'd0, digit_out}, 32'hFE);
      wait_frame("restart");
      value_in    = 32'h0000_00A0;
      value_valid = 1'b1;
      check_frame("discard", 32'h0);
      check_frame("A0", 32'h0000_00A0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
